// File: rtl/rtc_apb_pkg.sv
// Shared types for the RTC APB requester: FSM state encoding and the
// registered response bundle returned to the host.
package rtc_apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    // Widest data bus the response bundle can carry; narrower buses zero-extend.
    localparam int RSP_DATA_MAX = 64;

    typedef struct packed {
        logic [RSP_DATA_MAX-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } rsp_t;

endpackage

// File: rtl/rtc_apb_master.sv
// APB requester: one single read/write transfer per valid/ready command,
// with a bounded PREADY wait so a dead slave cannot hang the host.
module rtc_apb_master
    import rtc_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,

    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    rsp_t             rsp_q;
    logic             timeout_hit;

    // The abort fires in the ACCESS cycle after the counter has reached TIMEOUT,
    // so a stuck slave sees TIMEOUT+1 ACCESS cycles before PSEL drops.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));

    assign req_ready_o   = (state == IDLE) && !rst_i;
    assign rsp_rdata_o   = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rsp_q       <= '0;
            rsp_valid_o <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        PWRITE   <= req_write_i;
                        PADDR    <= req_addr_i;
                        PWDATA   <= req_wdata_i;
                        wait_cnt <= '0;
                        PSEL     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_q.rdata   <= PWRITE ? '0 : RSP_DATA_MAX'(PRDATA);
                        rsp_q.err     <= PSLVERR;
                        rsp_q.timeout <= 1'b0;
                        PSEL          <= 1'b0;
                        PENABLE       <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else if (timeout_hit) begin
                        rsp_q.rdata   <= '0;
                        rsp_q.err     <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        PSEL          <= 1'b0;
                        PENABLE       <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_apb_master.sv
// Directed bench for rtc_apb_master: a simple APB slave model plus a
// scoreboard of expected responses checked with immediate assertions.
module tb_rtc_apb_master;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
    logic [31:0] rsp_rdata_o;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];

    // slave model knobs
    int          wait_n = 0;
    logic        stuck = 1'b0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    int          acc_cnt = 0;

    rtc_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 clk = ~clk;

    assign PREADY  = PSEL && PENABLE && !stuck && (acc_cnt >= wait_n);
    assign PRDATA  = slv_rdata;
    assign PSLVERR = slv_err;

    always @(posedge clk) begin
        if (!(PSEL && PENABLE)) acc_cnt <= 0;
        else if (!PREADY)       acc_cnt <= acc_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = d;
    endtask

    task automatic push(input logic [31:0] rd, input logic e, input logic t);
        exp_t x;
        x.rdata = rd; x.err = e; x.timeout = t;
        sb.push_back(x);
    endtask

    // Ticks until rsp_valid_o, checking PADDR stays put and latency matches.
    task automatic wait_rsp(input string tag, input int max, input int exp_n, input logic [31:0] addr);
        int   n = 0;
        logic moved = 1'b0;
        while (!rsp_valid_o && n < max) begin
            tick();
            n++;
            if (PADDR !== addr) moved = 1'b1;
        end
        chk({tag, "_rsp_seen"}, 64'(rsp_valid_o), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(exp_n));
        chk({tag, "_paddr_stable"}, 64'(moved), 64'd0);
        chk({tag, "_psel_low"}, 64'(PSEL), 64'd0);
    endtask

    task automatic cmp_rsp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(e.rdata));
            chk({tag, "_err"}, 64'(rsp_err_o), 64'(e.err));
            chk({tag, "_timeout"}, 64'(rsp_timeout_o), 64'(e.timeout));
        end
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        tick(); tick();
        chk("rst_psel", 64'(PSEL), 0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
        chk("rst_req_ready", 64'(req_ready_o), 0);
        chk("rst_paddr", 64'(PADDR), 0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_req_ready", 64'(req_ready_o), 1);

        // 1: zero-wait write
        send(1'b1, 32'h0000_0010, 32'h0000_002A);
        push(32'h0, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        chk("wr_setup_psel", 64'(PSEL), 1);
        chk("wr_setup_penable", 64'(PENABLE), 0);
        chk("wr_setup_req_ready", 64'(req_ready_o), 0);
        chk("wr_pwrite", 64'(PWRITE), 1);
        chk("wr_paddr", 64'(PADDR), 64'h10);
        chk("wr_pwdata", 64'(PWDATA), 64'h2A);
        tick();
        chk("wr_access_psel", 64'(PSEL), 1);
        chk("wr_access_penable", 64'(PENABLE), 1);
        wait_rsp("wr", 10, 1, 32'h10);
        cmp_rsp("wr");
        tick();
        chk("wr_req_ready_again", 64'(req_ready_o), 1);
        chk("wr_rsp_dropped", 64'(rsp_valid_o), 0);

        // 2: read with 3 wait cycles
        wait_n = 3; slv_rdata = 32'h1234_5678;
        send(1'b0, 32'h0000_0020, 32'hFFFF_FFFF);
        push(32'h1234_5678, 1'b0, 1'b0);
        wait_rsp("rd_wait", 20, 6, 32'h20);
        req_valid_i = 1'b0;
        cmp_rsp("rd_wait");
        tick();

        // 3: read with PSLVERR
        wait_n = 0; slv_err = 1'b1; slv_rdata = 32'hDEAD_BEEF;
        send(1'b0, 32'h0000_0024, 32'h0);
        push(32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        req_valid_i = 1'b0;
        wait_rsp("rd_err", 10, 2, 32'h24);
        cmp_rsp("rd_err");
        slv_err = 1'b0;
        tick();

        // 4: stuck slave, timeout abort after TIMEOUT+1 ACCESS cycles
        stuck = 1'b1; slv_rdata = 32'hAAAA_5555;
        send(1'b0, 32'h0000_0028, 32'h0);
        push(32'h0, 1'b1, 1'b1);
        tick();
        req_valid_i = 1'b0;
        wait_rsp("tmo", 40, 18, 32'h28);
        cmp_rsp("tmo");
        stuck = 1'b0;
        tick();

        // 5: response back-pressure with a pending command
        rsp_ready_i = 1'b0;
        send(1'b1, 32'h0000_0030, 32'h0000_0055);
        push(32'h0, 1'b0, 1'b0);
        tick();
        send(1'b0, 32'h0000_0040, 32'h0);
        wait_rsp("bp", 10, 2, 32'h30);
        cmp_rsp("bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 64'(rsp_valid_o), 1);
            chk("bp_hold_rdata", 64'(rsp_rdata_o), 0);
            chk("bp_hold_err", 64'(rsp_err_o), 0);
            chk("bp_req_ready_low", 64'(req_ready_o), 0);
            chk("bp_paddr_held", 64'(PADDR), 64'h30);
        end
        rsp_ready_i = 1'b1;
        slv_rdata = 32'hCAFE_F00D;
        push(32'hCAFE_F00D, 1'b0, 1'b0);
        tick();
        chk("bp_handshake_done", 64'(rsp_valid_o), 0);
        chk("bp_req_ready_high", 64'(req_ready_o), 1);
        tick();
        req_valid_i = 1'b0;
        chk("bp_next_setup", 64'(PSEL), 1);
        chk("bp_next_paddr", 64'(PADDR), 64'h40);
        wait_rsp("bp_next", 10, 2, 32'h40);
        cmp_rsp("bp_next");
        tick();

        // 6: reset during ACCESS
        stuck = 1'b1;
        send(1'b0, 32'h0000_0050, 32'h0);
        tick();
        req_valid_i = 1'b0;
        tick(); tick();
        chk("mid_in_access", 64'(PENABLE), 1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_psel", 64'(PSEL), 0);
        chk("mid_rst_penable", 64'(PENABLE), 0);
        chk("mid_rst_pwrite", 64'(PWRITE), 0);
        chk("mid_rst_paddr", 64'(PADDR), 0);
        chk("mid_rst_pwdata", 64'(PWDATA), 0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid_o), 0);
        chk("mid_rst_rdata", 64'(rsp_rdata_o), 0);
        chk("mid_rst_err", 64'(rsp_err_o), 0);
        chk("mid_rst_timeout", 64'(rsp_timeout_o), 0);
        chk("mid_rst_req_ready", 64'(req_ready_o), 0);
        tick(); tick();
        chk("mid_rst_no_rsp", 64'(rsp_valid_o), 0);
        stuck = 1'b0;
        rst_i = 1'b0;
        send(1'b1, 32'h0000_0060, 32'h0000_0077);
        push(32'h0, 1'b0, 1'b0);
        #1;
        chk("rel_req_ready", 64'(req_ready_o), 1);
        tick();
        req_valid_i = 1'b0;
        chk("rel_setup_psel", 64'(PSEL), 1);
        chk("rel_setup_paddr", 64'(PADDR), 64'h60);
        chk("rel_setup_pwdata", 64'(PWDATA), 64'h77);
        wait_rsp("rel", 10, 2, 32'h60);
        cmp_rsp("rel");
        tick();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: observed=expired expected=finished");
        $fatal(1, "time limit");
    end

endmodule
